exec_stage: RTL and testbench

//  RV32I execute stage: consumes forwarded operands and the stall qualifier from the hazard/forwarding unit.

---
 rtl/exec_pkg.sv | 47 ++++
 rtl/exec_alu.sv | 62 ++++++
 rtl/exec_stage.sv | 144 ++++++++++++++
 tb/tb_exec_stage.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared RV32I execute-stage encodings, used by decode and exec_stage.
// Also holds the RUN/SHADOW redirect state type and the CSR write-value helper.
package exec_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_LUI   = 4'd10;
  localparam logic [3:0] ALU_AUIPC = 4'd11;

  // Branch codes follow funct3; 3'b010 is unused by RV32I branches, so it marks "not a branch".
  localparam logic [2:0] BR_EQ   = 3'b000;
  localparam logic [2:0] BR_NE   = 3'b001;
  localparam logic [2:0] BR_NONE = 3'b010;
  localparam logic [2:0] BR_LT   = 3'b100;
  localparam logic [2:0] BR_GE   = 3'b101;
  localparam logic [2:0] BR_LTU  = 3'b110;
  localparam logic [2:0] BR_GEU  = 3'b111;

  localparam logic [1:0] CSR_NONE = 2'd0;
  localparam logic [1:0] CSR_RW   = 2'd1;
  localparam logic [1:0] CSR_RS   = 2'd2;
  localparam logic [1:0] CSR_RC   = 2'd3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } redir_state_t;

  function automatic logic [31:0] csr_update(input logic [1:0] op, input logic [31:0] old_val,
                                             input logic [31:0] src);
    case (op)
      CSR_RW:  csr_update = src;
      CSR_RS:  csr_update = old_val | src;
      CSR_RC:  csr_update = old_val & ~src;
      default: csr_update = old_val;
    endcase
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational execute datapath: ALU, branch compare and control-transfer target adder.
module exec_alu
  import exec_pkg::*;
(
  input  logic [3:0]  alu_op,
  input  logic [2:0]  br_op,
  input  logic        is_jalr,
  input  logic        use_imm,
  input  logic [31:0] pc,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [31:0] imm,
  output logic [31:0] alu_result,
  output logic [31:0] eff_addr,
  output logic [31:0] link_addr,
  output logic [31:0] target,
  output logic        br_taken
);

  logic [31:0] op_b;
  logic [4:0]  shamt;

  assign op_b      = use_imm ? imm : op2;
  assign shamt     = op_b[4:0];
  assign eff_addr  = op1 + imm;
  assign link_addr = pc + 32'd4;
  assign target    = is_jalr ? (eff_addr & ~32'd1) : (pc + imm);

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD:   alu_result = op1 + op_b;
      ALU_SUB:   alu_result = op1 - op_b;
      ALU_SLL:   alu_result = op1 << shamt;
      ALU_SLT:   alu_result = {31'd0, $signed(op1) < $signed(op_b)};
      ALU_SLTU:  alu_result = {31'd0, op1 < op_b};
      ALU_XOR:   alu_result = op1 ^ op_b;
      ALU_SRL:   alu_result = op1 >> shamt;
      ALU_SRA:   alu_result = $unsigned($signed(op1) >>> shamt);
      ALU_OR:    alu_result = op1 | op_b;
      ALU_AND:   alu_result = op1 & op_b;
      ALU_LUI:   alu_result = op_b;
      ALU_AUIPC: alu_result = pc + op_b;
      default:   alu_result = '0;
    endcase
  end

  // Branches always compare the two register operands, never the immediate.
  always_comb begin
    br_taken = 1'b0;
    case (br_op)
      BR_EQ:   br_taken = (op1 == op2);
      BR_NE:   br_taken = (op1 != op2);
      BR_LT:   br_taken = ($signed(op1) < $signed(op2));
      BR_GE:   br_taken = ($signed(op1) >= $signed(op2));
      BR_LTU:  br_taken = (op1 < op2);
      BR_GEU:  br_taken = (op1 >= op2);
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// RV32I execute stage: EX/MEM pipeline register, ID/EX and EX/MEM handshakes, redirect FSM.
// state     | meaning
// ST_RUN    | normal issue; a taken jump/branch pulses redirect and enters ST_SHADOW
// ST_SHADOW | next fired instruction is the wrong-path slot and is consumed as a bubble
module exec_stage
  import exec_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] PC_stage1,
  input  logic [3:0]      alu_op,
  input  logic [2:0]      br_op,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            use_imm,
  input  logic [XLEN-1:0] imm,
  input  logic [5:0]      rd_stage1,
  input  logic            write_reg_stage1,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [1:0]      mem_size,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_stage1,
  input  logic            csr_write,
  input  logic [XLEN-1:0] operand1_into_exec,
  input  logic [XLEN-1:0] operand2_into_exec,
  input  logic [XLEN-1:0] csr_into_exec,
  input  logic            rs1_rs2_valid,
  input  logic            flush,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] PC_stage2,
  output logic [5:0]      destination_reg_stage2,
  output logic            write_reg_stage2,
  output logic [XLEN-1:0] rd_result_stage2,
  output logic [XLEN-1:0] store_data,
  output logic            memstage_load_into_reg,
  output logic [1:0]      mem_size_stage2,
  output logic [11:0]     csr_destination_reg_stage2,
  output logic            csr_write_reg_stage2,
  output logic [XLEN-1:0] csr_memstage_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            misalign_exc
);

  redir_state_t state;
  logic         fire;
  logic         ctl_taken;
  logic         br_taken;
  logic         wr_q, ld_q, csrw_q;
  logic [31:0]  alu_result, eff_addr, link_addr, target;
  logic [31:0]  result_d;

  exec_alu u_alu (
    .alu_op     (alu_op),
    .br_op      (br_op),
    .is_jalr    (is_jalr),
    .use_imm    (use_imm),
    .pc         (PC_stage1),
    .op1        (operand1_into_exec),
    .op2        (operand2_into_exec),
    .imm        (imm),
    .alu_result (alu_result),
    .eff_addr   (eff_addr),
    .link_addr  (link_addr),
    .target     (target),
    .br_taken   (br_taken)
  );

  assign id_ready  = rs1_rs2_valid & ~flush & (~mem_valid | mem_ready);
  assign fire      = id_valid & id_ready;
  assign ctl_taken = is_jal | is_jalr | br_taken;

  always_comb begin
    result_d = alu_result;
    if (is_load || is_store)    result_d = eff_addr;
    else if (is_jal || is_jalr) result_d = link_addr;
    else if (csr_op != CSR_NONE) result_d = csr_into_exec;
  end

  // Stage-2 enables are gated by mem_valid so a bubble can never forward.
  assign write_reg_stage2       = wr_q & mem_valid;
  assign memstage_load_into_reg = ld_q & mem_valid;
  assign csr_write_reg_stage2   = csrw_q & mem_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                      <= ST_RUN;
      mem_valid                  <= 1'b0;
      redirect_valid             <= 1'b0;
      misalign_exc               <= 1'b0;
      redirect_pc                <= RESET_PC;
      PC_stage2                  <= RESET_PC;
      destination_reg_stage2     <= '0;
      wr_q                       <= 1'b0;
      rd_result_stage2           <= '0;
      store_data                 <= '0;
      ld_q                       <= 1'b0;
      mem_size_stage2            <= '0;
      csr_destination_reg_stage2 <= '0;
      csrw_q                     <= 1'b0;
      csr_memstage_data          <= '0;
    end else begin
      redirect_valid <= 1'b0;
      misalign_exc   <= 1'b0;
      if (flush) begin
        state <= ST_RUN;
      end else if (fire) begin
        if (state == ST_SHADOW) begin
          state <= ST_RUN;
        end else if (ctl_taken) begin
          state          <= ST_SHADOW;
          redirect_valid <= 1'b1;
          redirect_pc    <= target;
          misalign_exc   <= target[1];
        end
      end

      // The wrong-path slot is consumed without loading; an in-flight entry may retire on the same edge.
      if (fire && state == ST_RUN) begin
        mem_valid                  <= 1'b1;
        PC_stage2                  <= PC_stage1;
        destination_reg_stage2     <= rd_stage1;
        wr_q                       <= write_reg_stage1;
        rd_result_stage2           <= result_d;
        store_data                 <= operand2_into_exec;
        ld_q                       <= is_load;
        mem_size_stage2            <= mem_size;
        csr_destination_reg_stage2 <= csr_stage1;
        csrw_q                     <= csr_write;
        csr_memstage_data          <= csr_update(csr_op, csr_into_exec, operand1_into_exec);
      end else if (mem_ready) begin
        mem_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_exec_stage;
  import exec_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [2:0]  br_op;
    logic        jal, jalr, use_imm;
    logic [31:0] imm;
    logic [5:0]  rd;
    logic        wr, ld, st;
    logic [1:0]  size, csr_op;
    logic [11:0] csr_addr;
    logic        csr_wr;
    logic [31:0] op1, op2, csr_old;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_ready;
  logic [31:0] PC_stage1;
  logic [3:0]  alu_op;
  logic [2:0]  br_op;
  logic        is_jal, is_jalr, use_imm;
  logic [31:0] imm;
  logic [5:0]  rd_stage1;
  logic        write_reg_stage1, is_load, is_store;
  logic [1:0]  mem_size, csr_op;
  logic [11:0] csr_stage1;
  logic        csr_write;
  logic [31:0] operand1_into_exec, operand2_into_exec, csr_into_exec;
  logic        rs1_rs2_valid, flush;
  logic        mem_valid, mem_ready;
  logic [31:0] PC_stage2;
  logic [5:0]  destination_reg_stage2;
  logic        write_reg_stage2;
  logic [31:0] rd_result_stage2, store_data;
  logic        memstage_load_into_reg;
  logic [1:0]  mem_size_stage2;
  logic [11:0] csr_destination_reg_stage2;
  logic        csr_write_reg_stage2;
  logic [31:0] csr_memstage_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_exc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exec_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .PC_stage1(PC_stage1), .alu_op(alu_op), .br_op(br_op), .is_jal(is_jal), .is_jalr(is_jalr),
    .use_imm(use_imm), .imm(imm), .rd_stage1(rd_stage1), .write_reg_stage1(write_reg_stage1),
    .is_load(is_load), .is_store(is_store), .mem_size(mem_size), .csr_op(csr_op),
    .csr_stage1(csr_stage1), .csr_write(csr_write), .operand1_into_exec(operand1_into_exec),
    .operand2_into_exec(operand2_into_exec), .csr_into_exec(csr_into_exec),
    .rs1_rs2_valid(rs1_rs2_valid), .flush(flush), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .PC_stage2(PC_stage2), .destination_reg_stage2(destination_reg_stage2),
    .write_reg_stage2(write_reg_stage2), .rd_result_stage2(rd_result_stage2),
    .store_data(store_data), .memstage_load_into_reg(memstage_load_into_reg),
    .mem_size_stage2(mem_size_stage2), .csr_destination_reg_stage2(csr_destination_reg_stage2),
    .csr_write_reg_stage2(csr_write_reg_stage2), .csr_memstage_data(csr_memstage_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .misalign_exc(misalign_exc)
  );

  // ---------------- reference model (instruction-level semantics) ----------------
  function automatic logic [31:0] m_alu(input instr_t i);
    logic [31:0] b, ones;
    int sh;
    b    = i.use_imm ? i.imm : i.op2;
    sh   = int'(b[4:0]);
    ones = '1;
    case (i.alu_op)
      ALU_ADD:   return i.op1 + b;
      ALU_SUB:   return i.op1 - b;
      ALU_SLL:   return i.op1 << sh;
      ALU_SLT:   return ($signed(i.op1) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:  return (i.op1 < b) ? 32'd1 : 32'd0;
      ALU_XOR:   return i.op1 ^ b;
      ALU_SRL:   return i.op1 >> sh;
      ALU_SRA:   return (i.op1 >> sh) | (i.op1[31] ? ~(ones >> sh) : 32'd0);
      ALU_OR:    return i.op1 | b;
      ALU_AND:   return i.op1 & b;
      ALU_LUI:   return b;
      ALU_AUIPC: return i.pc + b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic logic m_taken(input instr_t i);
    if (i.jal || i.jalr) return 1'b1;
    case (i.br_op)
      BR_EQ:  return i.op1 == i.op2;
      BR_NE:  return i.op1 != i.op2;
      BR_LT:  return $signed(i.op1) < $signed(i.op2);
      BR_GE:  return !($signed(i.op1) < $signed(i.op2));
      BR_LTU: return i.op1 < i.op2;
      BR_GEU: return !(i.op1 < i.op2);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target(input instr_t i);
    if (i.jalr) return (i.op1 + i.imm) & 32'hFFFF_FFFE;
    return i.pc + i.imm;
  endfunction

  function automatic logic [31:0] m_result(input instr_t i);
    if (i.ld || i.st) return i.op1 + i.imm;
    if (i.jal || i.jalr) return i.pc + 32'd4;
    if (i.csr_op != CSR_NONE) return i.csr_old;
    return m_alu(i);
  endfunction

  function automatic logic [31:0] m_csr(input instr_t i);
    case (i.csr_op)
      CSR_RW:  return i.op1;
      CSR_RS:  return i.csr_old | i.op1;
      CSR_RC:  return i.csr_old & ~i.op1;
      default: return i.csr_old;
    endcase
  endfunction

  function automatic instr_t nop_instr();
    instr_t i;
    i = '{pc: 32'd0, alu_op: ALU_ADD, br_op: BR_NONE, jal: 1'b0, jalr: 1'b0, use_imm: 1'b0,
          imm: 32'd0, rd: 6'd0, wr: 1'b0, ld: 1'b0, st: 1'b0, size: 2'd0, csr_op: CSR_NONE,
          csr_addr: 12'd0, csr_wr: 1'b0, op1: 32'd0, op2: 32'd0, csr_old: 32'd0};
    return i;
  endfunction

  function automatic instr_t alu_instr(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [5:0] rd);
    instr_t i;
    i = nop_instr();
    i.alu_op = op; i.op1 = a; i.op2 = b; i.rd = rd; i.wr = 1'b1;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    PC_stage1 = i.pc; alu_op = i.alu_op; br_op = i.br_op; is_jal = i.jal; is_jalr = i.jalr;
    use_imm = i.use_imm; imm = i.imm; rd_stage1 = i.rd; write_reg_stage1 = i.wr;
    is_load = i.ld; is_store = i.st; mem_size = i.size; csr_op = i.csr_op;
    csr_stage1 = i.csr_addr; csr_write = i.csr_wr; operand1_into_exec = i.op1;
    operand2_into_exec = i.op2; csr_into_exec = i.csr_old;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; id_valid = 1'b0; mem_ready = 1'b1; rs1_rs2_valid = 1'b1; flush = 1'b0;
    drive(nop_instr());
    tick(); tick();
    n_checks++;
    if ({mem_valid, redirect_valid, misalign_exc, write_reg_stage2, memstage_load_into_reg,
         csr_write_reg_stage2} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000", {mem_valid, redirect_valid,
        misalign_exc, write_reg_stage2, memstage_load_into_reg, csr_write_reg_stage2});
    end
    n_checks++;
    if ({PC_stage2, rd_result_stage2, store_data, csr_memstage_data, redirect_pc} !== 160'd0) begin
      n_fail++; $display("FAIL reset_data: pc2=%h res=%h sd=%h csr=%h rpc=%h want all 0",
        PC_stage2, rd_result_stage2, store_data, csr_memstage_data, redirect_pc);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    drive(alu_instr(ALU_ADD, 32'd5, 32'd7, 6'd3));
    id_valid = 1'b1; mem_ready = 1'b1;
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready: got %b want 1", id_ready); end
    tick();
    id_valid = 1'b0;
    n_checks++;
    if ({mem_valid, rd_result_stage2, destination_reg_stage2, write_reg_stage2} !== {1'b1, 32'd12, 6'd3, 1'b1}) begin
      n_fail++; $display("FAIL add_result: valid=%b res=%0d rd=%0d wr=%b want 1 12 3 1",
        mem_valid, rd_result_stage2, destination_reg_stage2, write_reg_stage2);
    end
    tick();
    n_checks++;
    if ({mem_valid, write_reg_stage2} !== 2'b00) begin
      n_fail++; $display("FAIL add_bubble: valid=%b wr=%b want 0 0", mem_valid, write_reg_stage2);
    end
  endtask

  task automatic test_operand_stall();
    drive(alu_instr(ALU_ADD, 32'd1, 32'd2, 6'd4));
    id_valid = 1'b1; rs1_rs2_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (id_ready !== 1'b0) begin n_fail++; $display("FAIL opstall_ready c%0d: got %b want 0", c, id_ready); end
      tick();
      n_checks++;
      if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL opstall_nofire c%0d: got %b want 0", c, mem_valid); end
    end
    rs1_rs2_valid = 1'b1;
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin n_fail++; $display("FAIL opstall_release: got %b want 1", id_ready); end
    tick();
    id_valid = 1'b0;
    n_checks++;
    if ({mem_valid, rd_result_stage2, destination_reg_stage2} !== {1'b1, 32'd3, 6'd4}) begin
      n_fail++; $display("FAIL opstall_result: valid=%b res=%0d rd=%0d want 1 3 4",
        mem_valid, rd_result_stage2, destination_reg_stage2);
    end
    tick();
  endtask

  task automatic test_backpressure();
    drive(alu_instr(ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 6'd7));
    id_valid = 1'b1; mem_ready = 1'b0;
    tick();
    drive(alu_instr(ALU_ADD, 32'd1, 32'd1, 6'd8));
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({mem_valid, rd_result_stage2, destination_reg_stage2, write_reg_stage2} !== {1'b1, 32'h0000_FF00, 6'd7, 1'b1}) begin
        n_fail++; $display("FAIL bp_hold c%0d: valid=%b res=%h rd=%0d wr=%b want 1 0000ff00 7 1",
          c, mem_valid, rd_result_stage2, destination_reg_stage2, write_reg_stage2);
      end
      #1;
      n_checks++;
      if (id_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready c%0d: got %b want 0", c, id_ready); end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if (id_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", id_ready); end
    tick();
    id_valid = 1'b0;
    n_checks++;
    if ({mem_valid, rd_result_stage2, destination_reg_stage2} !== {1'b1, 32'd2, 6'd8}) begin
      n_fail++; $display("FAIL bp_next: valid=%b res=%0d rd=%0d want 1 2 8",
        mem_valid, rd_result_stage2, destination_reg_stage2);
    end
    tick();
  endtask

  task automatic test_branch();
    instr_t i;
    i = nop_instr();
    i.br_op = BR_EQ; i.op1 = 32'd9; i.op2 = 32'd9; i.pc = 32'h100; i.imm = 32'h20;
    drive(i);
    id_valid = 1'b1; mem_ready = 1'b1;
    tick();
    n_checks++;
    if ({redirect_valid, redirect_pc, misalign_exc} !== {1'b1, 32'h120, 1'b0}) begin
      n_fail++; $display("FAIL beq_redirect: rv=%b rpc=%h mis=%b want 1 00000120 0",
        redirect_valid, redirect_pc, misalign_exc);
    end
    drive(alu_instr(ALU_ADD, 32'd100, 32'd1, 6'd5));
    tick();
    n_checks++;
    if ({redirect_valid, mem_valid, write_reg_stage2} !== 3'b000) begin
      n_fail++; $display("FAIL beq_shadow: rv=%b valid=%b wr=%b want 0 0 0",
        redirect_valid, mem_valid, write_reg_stage2);
    end
    drive(alu_instr(ALU_ADD, 32'd2, 32'd2, 6'd6));
    tick();
    id_valid = 1'b0;
    n_checks++;
    if ({mem_valid, rd_result_stage2, destination_reg_stage2} !== {1'b1, 32'd4, 6'd6}) begin
      n_fail++; $display("FAIL beq_resume: valid=%b res=%0d rd=%0d want 1 4 6",
        mem_valid, rd_result_stage2, destination_reg_stage2);
    end
    tick();
  endtask

  task automatic test_flush();
    instr_t i;
    i = nop_instr();
    i.br_op = BR_NE; i.op1 = 32'd1; i.op2 = 32'd2; i.pc = 32'h80; i.imm = 32'hFFFF_FFF8;
    drive(i);
    id_valid = 1'b1;
    tick();
    n_checks++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h78}) begin
      n_fail++; $display("FAIL bne_redirect: rv=%b rpc=%h want 1 00000078", redirect_valid, redirect_pc);
    end
    drive(alu_instr(ALU_ADD, 32'd5, 32'd5, 6'd10));
    flush = 1'b1;
    #1;
    n_checks++;
    if (id_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", id_ready); end
    tick();
    flush = 1'b0;
    n_checks++;
    if ({redirect_valid, mem_valid} !== 2'b00) begin
      n_fail++; $display("FAIL flush_state: rv=%b valid=%b want 0 0", redirect_valid, mem_valid);
    end
    tick();
    id_valid = 1'b0;
    n_checks++;
    if ({mem_valid, rd_result_stage2} !== {1'b1, 32'd10}) begin
      n_fail++; $display("FAIL flush_resume: valid=%b res=%0d want 1 10", mem_valid, rd_result_stage2);
    end
    tick();
  endtask

  task automatic test_csr();
    instr_t i;
    i = nop_instr();
    i.csr_op = CSR_RS; i.csr_old = 32'h0F; i.op1 = 32'hF0; i.csr_addr = 12'h300;
    i.csr_wr = 1'b1; i.rd = 6'd9; i.wr = 1'b1;
    drive(i);
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    n_checks++;
    if ({mem_valid, rd_result_stage2, csr_memstage_data, csr_write_reg_stage2, csr_destination_reg_stage2}
        !== {1'b1, 32'h0F, 32'hFF, 1'b1, 12'h300}) begin
      n_fail++; $display("FAIL csrrs: valid=%b res=%h data=%h cw=%b addr=%h want 1 0000000f 000000ff 1 300",
        mem_valid, rd_result_stage2, csr_memstage_data, csr_write_reg_stage2, csr_destination_reg_stage2);
    end
    tick();
  endtask

  task automatic test_jalr_reset();
    instr_t i;
    i = nop_instr();
    i.jalr = 1'b1; i.op1 = 32'h203; i.imm = 32'd0; i.pc = 32'h40; i.rd = 6'd1; i.wr = 1'b1;
    drive(i);
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    n_checks++;
    if ({redirect_valid, redirect_pc, misalign_exc, rd_result_stage2} !== {1'b1, 32'h202, 1'b1, 32'h44}) begin
      n_fail++; $display("FAIL jalr: rv=%b rpc=%h mis=%b link=%h want 1 00000202 1 00000044",
        redirect_valid, redirect_pc, misalign_exc, rd_result_stage2);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({mem_valid, redirect_valid, misalign_exc, write_reg_stage2, PC_stage2, rd_result_stage2, redirect_pc}
        !== 100'd0) begin
      n_fail++; $display("FAIL shadow_reset: valid=%b rv=%b mis=%b wr=%b pc2=%h res=%h rpc=%h want all 0",
        mem_valid, redirect_valid, misalign_exc, write_reg_stage2, PC_stage2, rd_result_stage2, redirect_pc);
    end
    drive(alu_instr(ALU_ADD, 32'd3, 32'd4, 6'd2));
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    n_checks++;
    if ({mem_valid, rd_result_stage2} !== {1'b1, 32'd7}) begin
      n_fail++; $display("FAIL reset_run: valid=%b res=%0d want 1 7", mem_valid, rd_result_stage2);
    end
    tick();
  endtask

  // ---------------- randomized traffic against the model ----------------
  function automatic instr_t rand_instr();
    instr_t i;
    logic [31:0] r;
    i = nop_instr();
    i.pc = $urandom & 32'hFFFF_FFFC; i.op1 = $urandom; i.op2 = $urandom; i.imm = $urandom;
    i.csr_old = $urandom; r = $urandom;
    i.rd = r[5:0]; i.size = r[7:6]; i.csr_addr = r[19:8]; i.wr = r[20];
    case ($urandom_range(0, 5))
      0, 1: begin i.alu_op = 4'($urandom_range(0, 11)); i.use_imm = r[21]; i.wr = 1'b1; end
      2: begin
        case ($urandom_range(0, 5))
          0: i.br_op = BR_EQ; 1: i.br_op = BR_NE; 2: i.br_op = BR_LT;
          3: i.br_op = BR_GE; 4: i.br_op = BR_LTU; default: i.br_op = BR_GEU;
        endcase
        if (r[22]) i.op2 = i.op1;
      end
      3: begin i.jal = r[23]; i.jalr = ~r[23]; end
      4: begin i.ld = r[24]; i.st = ~r[24]; end
      default: begin i.csr_op = 2'($urandom_range(1, 3)); i.csr_wr = r[25]; end
    endcase
    return i;
  endfunction

  task automatic test_random();
    instr_t cur, held;
    logic m_valid, m_shadow, m_rv, m_mis, fire, exp_ready, prev_shadow;
    logic [31:0] m_rpc;
    logic [150:0] exp_pack, act_pack;
    m_valid = 1'b0; m_shadow = 1'b0; m_rv = 1'b0; m_mis = 1'b0; m_rpc = 32'd0;
    held = nop_instr();
    for (int c = 0; c < 400; c++) begin
      cur = rand_instr();
      drive(cur);
      id_valid      = ($urandom % 4) != 0;
      mem_ready     = ($urandom % 4) != 0;
      rs1_rs2_valid = ($urandom % 8) != 0;
      flush         = ($urandom % 16) == 0;
      #1;
      exp_ready = rs1_rs2_valid && !flush && (!m_valid || mem_ready);
      n_checks++;
      if (id_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", c, id_ready, exp_ready);
      end
      fire = id_valid && exp_ready;
      prev_shadow = m_shadow;
      m_rv = fire && !prev_shadow && m_taken(cur);
      m_mis = 1'b0;
      if (m_rv) begin m_rpc = m_target(cur); m_mis = m_rpc[1]; end
      if (flush) m_shadow = 1'b0;
      else if (fire) m_shadow = !prev_shadow && m_taken(cur);
      if (fire && !prev_shadow) begin held = cur; m_valid = 1'b1; end
      else if (mem_ready) m_valid = 1'b0;
      tick();
      exp_pack = {held.pc, m_result(held), held.op2, m_csr(held), held.rd, held.csr_addr,
                  held.size, held.wr, held.ld, held.csr_wr};
      act_pack = {PC_stage2, rd_result_stage2, store_data, csr_memstage_data, destination_reg_stage2,
                  csr_destination_reg_stage2, mem_size_stage2, write_reg_stage2,
                  memstage_load_into_reg, csr_write_reg_stage2};
      n_checks++;
      if (mem_valid !== m_valid || (m_valid ? (act_pack !== exp_pack) : (act_pack[2:0] !== 3'b000))) begin
        n_fail++; $display("FAIL rand_exmem c%0d: valid=%b pack=%h want valid=%b pack=%h",
          c, mem_valid, act_pack, m_valid, exp_pack);
      end
      n_checks++;
      if (redirect_valid !== m_rv || misalign_exc !== m_mis || (m_rv && redirect_pc !== m_rpc)) begin
        n_fail++; $display("FAIL rand_redirect c%0d: rv=%b rpc=%h mis=%b want %b %h %b",
          c, redirect_valid, redirect_pc, misalign_exc, m_rv, m_rpc, m_mis);
      end
    end
    id_valid = 1'b0; flush = 1'b0; rs1_rs2_valid = 1'b1; mem_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_operand_stall();
    test_backpressure();
    test_branch();
    test_flush();
    test_csr();
    test_jalr_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
